// File: rtl/conv2_pkg.sv
// Shared constants, state encoding and address types for the conv2 layer sequencer.
package conv2_pkg;

    localparam int IN_DIM  = 12;
    localparam int OUT_DIM = 8;
    localparam int K       = 5;
    localparam int N_CH    = 3;
    localparam int TAPS    = K * K;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

    typedef logic [7:0] in_addr_t;
    typedef logic [6:0] w_addr_t;
    typedef logic [5:0] out_addr_t;

    // v*12 as shift-add so no multiplier is inferred
    function automatic logic [7:0] times_in_dim(input logic [7:0] v);
        return (v << 3) + (v << 2);
    endfunction

endpackage

// File: rtl/conv2_tap_counter.sv
// kr/kc nested kernel-tap counter; wraps to tap 0 after the last tap.
module conv2_tap_counter
    import conv2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] kr,
    output logic [2:0] kc,
    output logic       last_tap
);

    localparam logic [2:0] K_LAST = 3'(K - 1);

    assign last_tap = (kr == K_LAST) && (kc == K_LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            kr <= '0;
            kc <= '0;
        end else if (en) begin
            if (kc == K_LAST) begin
                kc <= '0;
                kr <= (kr == K_LAST) ? 3'd0 : kr + 3'd1;
            end else begin
                kc <= kc + 3'd1;
            end
        end
    end

endmodule

// File: rtl/conv2_seq_ctrl.sv
// Conv2 sequencer: walks a 5x5 kernel over a 12x12 map for three 8x8 output channels.
module conv2_seq_ctrl
    import conv2_pkg::*;
#(
    parameter int RD_LAT = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       out_ready,
    output logic [7:0] in_addr,
    output logic [6:0] w_addr,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       out_we,
    output logic [5:0] out_addr,
    output logic [1:0] out_ch,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [2:0] DIM_LAST   = 3'(OUT_DIM - 1);
    localparam logic [1:0] CH_LAST    = 2'(N_CH - 1);

    state_t      state;
    logic [1:0]  ch;
    logic [1:0]  drain;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [2:0]  kr;
    logic [2:0]  kc;
    logic        last_tap;
    logic        issue;
    logic        tap0;
    logic        last_col;
    logic        last_row;
    logic        last_pixel;
    logic [RD_LAT-1:0] en_sr;
    logic [RD_LAT-1:0] clr_sr;
    in_addr_t    r_sum;
    in_addr_t    c_sum;
    w_addr_t     ch_w;
    w_addr_t     kr_w;

    assign issue      = (state == ISSUE);
    assign tap0       = issue && (kr == 3'd0) && (kc == 3'd0);
    assign last_col   = (col == DIM_LAST);
    assign last_row   = (row == DIM_LAST);
    assign last_pixel = (ch == CH_LAST) && last_row && last_col;

    conv2_tap_counter u_tap (
        .clk      (clk),
        .reset    (reset),
        .clr      (!issue),
        .en       (issue),
        .kr       (kr),
        .kc       (kc),
        .last_tap (last_tap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ch    <= '0;
            row   <= '0;
            col   <= '0;
            drain <= '0;
        end else begin
            case (state)
                IDLE:  if (start) state <= ISSUE;
                ISSUE: if (last_tap) state <= DRAIN;
                DRAIN: begin
                    if (drain == DRAIN_LAST) begin
                        drain <= '0;
                        state <= WRITE;
                    end else begin
                        drain <= drain + 2'd1;
                    end
                end
                WRITE: begin
                    if (out_ready) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row <= '0;
                                ch  <= (ch == CH_LAST) ? 2'd0 : ch + 2'd1;
                            end else begin
                                row <= row + 3'd1;
                            end
                        end else begin
                            col <= col + 3'd1;
                        end
                        state <= last_pixel ? DONE : ISSUE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tap strobes delayed by the memory read latency so mac_en meets the read data
    always_ff @(posedge clk) begin
        if (reset) begin
            en_sr  <= '0;
            clr_sr <= '0;
        end else begin
            en_sr[0]  <= issue;
            clr_sr[0] <= tap0;
            for (int i = 1; i < RD_LAT; i++) begin
                en_sr[i]  <= en_sr[i-1];
                clr_sr[i] <= clr_sr[i-1];
            end
        end
    end

    assign r_sum = 8'(row) + 8'(kr);
    assign c_sum = 8'(col) + 8'(kc);
    assign ch_w  = 7'(ch);
    assign kr_w  = 7'(kr);

    assign in_addr = issue ? times_in_dim(r_sum) + c_sum : '0;
    assign w_addr  = issue ? (ch_w << 4) + (ch_w << 3) + ch_w + (kr_w << 2) + kr_w + 7'(kc) : '0;

    assign mac_en  = en_sr[RD_LAT-1];
    assign mac_clr = clr_sr[RD_LAT-1];

    // Handshake: a write transfers in exactly the cycles where state is WRITE and
    // out_ready=1; out_we is that AND, and out_addr/out_ch hold steady while stalled.
    assign out_we    = (state == WRITE) && out_ready;
    assign out_addr  = (6'(row) << 3) + 6'(col);
    assign out_ch    = ch;
    assign busy      = (state == ISSUE) || (state == DRAIN) || (state == WRITE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_conv2_seq_ctrl.sv
// Directed bench for conv2_seq_ctrl: timing points, stalls, ignored start, abort, RD_LAT=3.
module tb_conv2_seq_ctrl;

    logic       clk;
    logic       reset, start, out_ready;
    logic [7:0] in_addr;
    logic [6:0] w_addr;
    logic       mac_clr, mac_en, out_we, busy, done;
    logic [5:0] out_addr;
    logic [1:0] out_ch;
    logic [2:0] state_dbg;

    logic       reset3, start3, out_ready3;
    logic [7:0] in_addr3;
    logic [6:0] w_addr3;
    logic       mac_clr3, mac_en3, out_we3, busy3, done3;
    logic [5:0] out_addr3;
    logic [1:0] out_ch3;
    logic [2:0] state_dbg3;

    int checks = 0;
    int errors = 0;
    int off = 0;
    int wr_cnt = 0, done_cnt = 0;
    int wr3_cnt = 0, done3_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp3_q[$];
    logic [7:0] exp_e, exp3_e;

    conv2_seq_ctrl #(.RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
        .in_addr(in_addr), .w_addr(w_addr), .mac_clr(mac_clr), .mac_en(mac_en),
        .out_we(out_we), .out_addr(out_addr), .out_ch(out_ch),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    conv2_seq_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset3), .start(start3), .out_ready(out_ready3),
        .in_addr(in_addr3), .w_addr(w_addr3), .mac_clr(mac_clr3), .mac_en(mac_en3),
        .out_we(out_we3), .out_addr(out_addr3), .out_ch(out_ch3),
        .busy(busy3), .done(done3), .state_dbg(state_dbg3)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (offset %0d)", name, act, exp, off);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        off++;
    endtask

    task automatic goto(input int t);
        while (off < t) tick;
    endtask

    // scoreboard monitors: expected {ch, addr} pairs are popped on every write
    always @(negedge clk) begin
        if (out_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got ch=%0d addr=%0d expected none", out_ch, out_addr);
            end else begin
                exp_e = exp_q.pop_front();
                chk("write_order", {out_ch, out_addr}, exp_e);
            end
        end
        if (done) done_cnt++;
    end

    always @(negedge clk) begin
        if (out_we3) begin
            wr3_cnt++;
            if (exp3_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write3: got ch=%0d addr=%0d expected none", out_ch3, out_addr3);
            end else begin
                exp3_e = exp3_q.pop_front();
                chk("write_order3", {out_ch3, out_addr3}, exp3_e);
            end
        end
        if (done3) done3_cnt++;
    end

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        reset3 = 1'b1; start3 = 1'b0; out_ready3 = 1'b1;
        repeat (3) tick;
        reset = 1'b0; reset3 = 1'b0;
        tick;

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst3_busy", busy3, 0);

        // run 1: full layer, stall on (ch1, addr9), stray start mid-layer
        for (int p = 0; p < 192; p++) exp_q.push_back(8'(p));
        start = 1'b1;
        tick;
        start = 1'b0;
        off = 0;
        chk("t0_in_addr", in_addr, 0);
        chk("t0_w_addr", w_addr, 0);
        chk("t0_busy", busy, 1);
        chk("t0_mac_en", mac_en, 0);
        goto(1);
        chk("t1_mac_en", mac_en, 1);
        chk("t1_mac_clr", mac_clr, 1);
        goto(2);
        chk("t2_mac_clr", mac_clr, 0);
        chk("t2_in_addr", in_addr, 2);
        goto(5);
        chk("t5_in_addr", in_addr, 12);
        chk("t5_w_addr", w_addr, 5);
        goto(24);
        chk("t24_in_addr", in_addr, 52);
        chk("t24_w_addr", w_addr, 24);
        goto(25);
        chk("t25_mac_en", mac_en, 1);
        chk("t25_busy", busy, 1);
        goto(26);
        chk("t26_out_we", out_we, 1);
        chk("t26_out_addr", out_addr, 0);
        goto(27);
        chk("t27_in_addr", in_addr, 1);
        chk("t27_mac_en", mac_en, 0);

        goto(1997);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_out_we", out_we, 0);
            chk("stall_mac_en", mac_en, 0);
            chk("stall_state", state_dbg, 3);
            chk("stall_out_addr", out_addr, 9);
            tick;
        end
        out_ready = 1'b1;
        #1;
        chk("release_out_we", out_we, 1);
        chk("release_out_ch", out_ch, 1);
        goto(2008);
        chk("after_stall_in_addr", in_addr, 14);
        chk("after_stall_w_addr", w_addr, 25);

        goto(3000);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("stray_start_busy", busy, 1);

        goto(5191);
        chk("last_tap_in_addr", in_addr, 143);
        chk("last_tap_w_addr", w_addr, 74);
        goto(5193);
        chk("last_out_we", out_we, 1);
        chk("last_out_ch", out_ch, 2);
        chk("last_out_addr", out_addr, 63);
        goto(5194);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        goto(5195);
        chk("done_clear", done, 0);
        chk("idle_state", state_dbg, 0);
        chk("run1_queue_left", exp_q.size(), 0);
        chk("run1_writes", wr_cnt, 192);
        chk("run1_done_cnt", done_cnt, 1);

        // run 2: reset during ISSUE of pixel 40 abandons the layer
        for (int p = 0; p < 40; p++) exp_q.push_back(8'(p));
        start = 1'b1;
        tick;
        start = 1'b0;
        off = 0;
        goto(40 * 27 + 5);
        chk("pre_abort_mac_en", mac_en, 1);
        reset = 1'b1;
        tick;
        chk("abort_busy", busy, 0);
        chk("abort_mac_en", mac_en, 0);
        chk("abort_mac_clr", mac_clr, 0);
        chk("abort_out_we", out_we, 0);
        chk("abort_in_addr", in_addr, 0);
        chk("abort_state", state_dbg, 0);
        reset = 1'b0;
        tick;
        chk("run2_queue_left", exp_q.size(), 0);
        chk("run2_writes", wr_cnt, 232);

        // run 3: fresh start after abort restarts at ch0 addr0
        for (int p = 0; p < 192; p++) exp_q.push_back(8'(p));
        start = 1'b1;
        tick;
        start = 1'b0;
        off = 0;
        chk("r3_t0_in_addr", in_addr, 0);
        chk("r3_t0_busy", busy, 1);
        goto(26);
        chk("r3_first_we", out_we, 1);
        chk("r3_first_addr", out_addr, 0);
        chk("r3_first_ch", out_ch, 0);
        goto(5184);
        chk("r3_done", done, 1);
        tick;
        chk("run3_queue_left", exp_q.size(), 0);
        chk("run3_writes", wr_cnt, 424);
        chk("run3_done_cnt", done_cnt, 2);

        // RD_LAT=3 instance: 29 cycles per pixel
        for (int p = 0; p < 192; p++) exp3_q.push_back(8'(p));
        start3 = 1'b1;
        tick;
        start3 = 1'b0;
        off = 0;
        chk("l3_t0_in_addr", in_addr3, 0);
        chk("l3_t0_mac_en", mac_en3, 0);
        goto(2);
        chk("l3_t2_mac_en", mac_en3, 0);
        goto(3);
        chk("l3_t3_mac_en", mac_en3, 1);
        chk("l3_t3_mac_clr", mac_clr3, 1);
        goto(4);
        chk("l3_t4_mac_clr", mac_clr3, 0);
        goto(27);
        chk("l3_t27_mac_en", mac_en3, 1);
        chk("l3_t27_out_we", out_we3, 0);
        goto(28);
        chk("l3_t28_out_we", out_we3, 1);
        chk("l3_t28_out_addr", out_addr3, 0);
        goto(29);
        chk("l3_t29_in_addr", in_addr3, 1);
        chk("l3_t29_mac_en", mac_en3, 0);
        goto(192 * 29);
        chk("l3_done", done3, 1);
        tick;
        chk("l3_queue_left", exp3_q.size(), 0);
        chk("l3_writes", wr3_cnt, 192);
        chk("l3_done_cnt", done3_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
